// File: rtl/seq_mult_core.sv
// Sequential shift-add multiplier: one multiplier bit per clock, signed/unsigned,
// optional accumulate into the product register with overflow flag.
module seq_mult_core #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic                 acc,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [PW-1:0]    r_mcand, r_sum;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_neg, r_acc, r_signed;

    logic             w_a_neg, w_b_neg, w_run_last, w_ovf;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [PW-1:0]    w_res;
    logic [PW:0]      w_sum;

    // Magnitudes fit in WIDTH unsigned bits, including |-2^(WIDTH-1)|.
    assign w_a_neg    = signed_mode & a[WIDTH-1];
    assign w_b_neg    = signed_mode & b[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -a : a;
    assign w_b_mag    = w_b_neg ? -b : b;
    assign w_run_last = (r_cnt == CW'(WIDTH));

    assign w_res = r_neg ? -r_sum : r_sum;
    assign w_sum = {1'b0, product} + {1'b0, w_res};
    assign w_ovf = r_signed ? ((product[PW-1] == w_res[PW-1]) && (w_sum[PW-1] != product[PW-1]))
                            : w_sum[PW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_run_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    // Product only changes on the RUN->DONE edge, so it never shows partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_sum    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_acc    <= 1'b0;
            r_signed <= 1'b0;
            product  <= '0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_sum    <= '0;
                        r_cnt    <= '0;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_acc    <= acc;
                        r_signed <= signed_mode;
                        overflow <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!w_run_last) begin
                        if (r_mplier[0]) r_sum <= r_sum + r_mcand;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end else begin
                        product  <= r_acc ? w_sum[PW-1:0] : w_res;
                        overflow <= r_acc & w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
